// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_nport register file: default sizes, word type
// and the one-hot address decoder used for write and reserve selects.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 8;
    localparam int NREGS_MAX = 32;
    localparam int AW_MAX    = $clog2(NREGS_MAX);

    typedef logic [XLEN_DEF-1:0] word_t;

    // Callers narrow the result to their own NREGS with a size cast.
    function automatic logic [NREGS_MAX-1:0] decode_onehot(input logic [AW_MAX-1:0] addr);
        logic [NREGS_MAX-1:0] sel;
        sel       = '0;
        sel[addr] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for regfile_nport: reserve/ack handshake, BUSY flags and
// the sticky write-error flag. REGFILE_BYPASS_EN hides BUSY for a register being written.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS    = NREGS_DEF,
    parameter  bit ZERO_REG = 1'b1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] a1,
    input  logic [AW-1:0] a2,
    input  logic [AW-1:0] a3,
    input  logic          we3,
    input  logic          res,
    input  logic [AW-1:0] ra,
    output logic          busy1,
    output logic          busy2,
    output logic          res_ack,
    output logic          werr
);

    logic [NREGS-1:0] pending_q, pending_d;
    logic             werr_q, werr_d;
    logic [NREGS-1:0] wr_sel, rs_sel;

    always_comb begin
        // NOTE: every always_comb output gets a value up front so no path infers a latch.
        wr_sel = we3 ? NREGS'(decode_onehot(AW_MAX'(a3))) : '0;
        rs_sel = res ? NREGS'(decode_onehot(AW_MAX'(ra))) : '0;
        // A hardwired zero register never becomes pending and a discarded write to it is no error.
        if (ZERO_REG) begin
            wr_sel[0] = 1'b0;
            rs_sel[0] = 1'b0;
        end
        // Writeback clears before reserve sets, so a same-register pair leaves the bit pending.
        pending_d = (pending_q & ~wr_sel) | rs_sel;
        werr_d    = werr_q | (|(wr_sel & ~pending_q));
        res_ack   = res & ~pending_q[ra] & ~rst;
        busy1     = pending_q[a1];
        busy2     = pending_q[a2];
`ifdef REGFILE_BYPASS_EN
        if (we3 && (a3 == a1)) busy1 = 1'b0;
        if (we3 && (a3 == a2)) busy2 = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            werr_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            werr_q    <= werr_d;
        end
    end

    assign werr = werr_q;

endmodule

// File: rtl/regfile_nport.sv
// Two-read/one-write register file with async reset, optional zero register and a
// pending-write scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_nport
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREGS    = NREGS_DEF,
    parameter  bit ZERO_REG = 1'b1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    input  logic [AW-1:0]   A3,
    input  logic            WE3,
    input  logic [XLEN-1:0] WD3,
    input  logic            RES,
    input  logic [AW-1:0]   RA,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            BUSY1,
    output logic            BUSY2,
    output logic            RES_ACK,
    output logic            WERR
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] wr_sel;
    logic [XLEN-1:0]  rd1_store, rd2_store;

    always_comb begin
        wr_sel = WE3 ? NREGS'(decode_onehot(AW_MAX'(A3))) : '0;
        if (ZERO_REG) wr_sel[0] = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = wr_sel[i] ? WD3 : regs_q[i];
        end
    end

    // NOTE: the array is reset because reads must show zero the instant RST rises;
    // a plain RAM without reset would not allow that.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            // NOTE: state updates use <= so every flop samples pre-edge values.
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_comb begin
        rd1_store = (ZERO_REG && (A1 == '0)) ? '0 : regs_q[A1];
        rd2_store = (ZERO_REG && (A2 == '0)) ? '0 : regs_q[A2];
`ifdef REGFILE_BYPASS_EN
        RD1 = rd1_store;
        RD2 = rd2_store;
        if (WE3 && !RST && (A3 == A1) && !(ZERO_REG && (A1 == '0))) RD1 = WD3;
        if (WE3 && !RST && (A3 == A2) && !(ZERO_REG && (A2 == '0))) RD2 = WD3;
`else
        RD1 = rd1_store;
        RD2 = rd2_store;
`endif
    end

    regfile_scoreboard #(
        .NREGS   (NREGS),
        .ZERO_REG(ZERO_REG)
    ) u_scoreboard (
        .clk    (CLK),
        .rst    (RST),
        .a1     (A1),
        .a2     (A2),
        .a3     (A3),
        .we3    (WE3),
        .res    (RES),
        .ra     (RA),
        .busy1  (BUSY1),
        .busy2  (BUSY2),
        .res_ack(RES_ACK),
        .werr   (WERR)
    );

endmodule

// File: tb/tb_regfile_nport.sv
// Self-checking bench for regfile_nport: two instances (ZERO_REG=1 and 0) compared every
// cycle against a register/pending-array model, plus directed literal checks.
module tb_regfile_nport;
    import regfile_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  a1, a2, a3, ra;
    logic        we3, res;
    word_t       wd3;

    word_t       rd1_o [2];
    word_t       rd2_o [2];
    logic        busy1_o [2];
    logic        busy2_o [2];
    logic        ack_o [2];
    logic        werr_o [2];

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_en   = 0;

    // Model state, index 1 = zero-register instance, index 0 = ordinary instance.
    word_t       mreg  [2][8];
    bit          mpend [2][8];
    bit          mwerr [2];

    regfile_nport #(.XLEN(32), .NREGS(8), .ZERO_REG(1'b1)) dut_z (
        .CLK(clk), .RST(rst), .A1(a1), .A2(a2), .A3(a3), .WE3(we3), .WD3(wd3),
        .RES(res), .RA(ra), .RD1(rd1_o[1]), .RD2(rd2_o[1]), .BUSY1(busy1_o[1]),
        .BUSY2(busy2_o[1]), .RES_ACK(ack_o[1]), .WERR(werr_o[1])
    );

    regfile_nport #(.XLEN(32), .NREGS(8), .ZERO_REG(1'b0)) dut_n (
        .CLK(clk), .RST(rst), .A1(a1), .A2(a2), .A3(a3), .WE3(we3), .WD3(wd3),
        .RES(res), .RA(ra), .RD1(rd1_o[0]), .RD2(rd2_o[0]), .BUSY1(busy1_o[0]),
        .BUSY2(busy2_o[0]), .RES_ACK(ack_o[0]), .WERR(werr_o[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic word_t exp_rd(input int z, input logic [2:0] a);
        if (z == 1 && a == 3'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (!rst && we3 && a3 == a) return wd3;
`endif
        return mreg[z][a];
    endfunction

    function automatic logic exp_busy(input int z, input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
        if (!rst && we3 && a3 == a) return 1'b0;
`endif
        return mpend[z][a];
    endfunction

    function automatic logic exp_ack(input int z);
        return res && !rst && !mpend[z][ra];
    endfunction

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            mwerr[z] = 1'b0;
            for (int r = 0; r < 8; r++) begin
                mreg[z][r]  = '0;
                mpend[z][r] = 1'b0;
            end
        end
    endtask

    task automatic model_update();
        if (rst) return;
        for (int z = 0; z < 2; z++) begin
            if (we3 && !(z == 1 && a3 == 3'd0)) begin
                if (!mpend[z][a3]) mwerr[z] = 1'b1;
                mreg[z][a3]  = wd3;
                mpend[z][a3] = 1'b0;
            end
            if (res && !(z == 1 && ra == 3'd0)) mpend[z][ra] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int z = 0; z < 2; z++) begin
                check($sformatf("z%0d_rd1", z),   rd1_o[z],   exp_rd(z, a1));
                check($sformatf("z%0d_rd2", z),   rd2_o[z],   exp_rd(z, a2));
                check($sformatf("z%0d_busy1", z), 32'(busy1_o[z]), 32'(exp_busy(z, a1)));
                check($sformatf("z%0d_busy2", z), 32'(busy2_o[z]), 32'(exp_busy(z, a2)));
                check($sformatf("z%0d_ack", z),   32'(ack_o[z]),   32'(exp_ack(z)));
                check($sformatf("z%0d_werr", z),  32'(werr_o[z]),  32'(mwerr[z]));
            end
        end
    end

    // Async reset asserted mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        for (int z = 0; z < 2; z++) begin
            check($sformatf("rst_z%0d_rd1", z),   rd1_o[z], 32'h0);
            check($sformatf("rst_z%0d_rd2", z),   rd2_o[z], 32'h0);
            check($sformatf("rst_z%0d_busy1", z), 32'(busy1_o[z]), 32'h0);
            check($sformatf("rst_z%0d_ack", z),   32'(ack_o[z]), 32'h0);
            check($sformatf("rst_z%0d_werr", z),  32'(werr_o[z]), 32'h0);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic idle();
        we3 = 1'b0;
        res = 1'b0;
    endtask

    initial begin
        rst = 1'b0; a1 = '0; a2 = '0; a3 = '0; ra = '0;
        we3 = 1'b0; res = 1'b0; wd3 = '0;
        model_reset();
        chk_en = 1;
        #3;
        res = 1'b1; ra = 3'd3; a1 = 3'd3; a2 = 3'd3;
        do_reset();
        idle();

        // Reserve then write register 3.
        res = 1'b1; ra = 3'd3; a1 = 3'd3;
        #1;
        check("basic_ack", 32'(ack_o[1]), 32'h1);
        check("basic_busy_pre", 32'(busy1_o[1]), 32'h0);
        tick();
        res = 1'b0;
        #1;
        check("basic_busy_set", 32'(busy1_o[1]), 32'h1);
        we3 = 1'b1; a3 = 3'd3; wd3 = 32'hDEADBEEF;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("basic_rd1_fwd", rd1_o[1], 32'hDEADBEEF);
        check("basic_busy_fwd", 32'(busy1_o[1]), 32'h0);
`else
        check("basic_rd1_old", rd1_o[1], 32'h0);
        check("basic_busy_wb", 32'(busy1_o[1]), 32'h1);
`endif
        tick();
        we3 = 1'b0;
        #1;
        check("basic_rd1", rd1_o[1], 32'hDEADBEEF);
        check("basic_busy_clr", 32'(busy1_o[1]), 32'h0);
        check("basic_werr", 32'(werr_o[1]), 32'h0);

        // Zero register vs ordinary register 0.
        we3 = 1'b1; a3 = 3'd0; wd3 = 32'h1234; a1 = 3'd0;
        tick();
        we3 = 1'b0;
        #1;
        check("zero_rd1_z", rd1_o[1], 32'h0);
        check("zero_rd1_n", rd1_o[0], 32'h1234);

        // Reserve conflict and same-cycle write+reserve.
        do_reset();
        res = 1'b1; ra = 3'd5; a1 = 3'd5;
        #1;
        check("conf_ack1", 32'(ack_o[1]), 32'h1);
        tick();
        #1;
        check("conf_ack2", 32'(ack_o[1]), 32'h0);
        check("conf_busy", 32'(busy1_o[1]), 32'h1);
        tick();
        we3 = 1'b1; a3 = 3'd5; wd3 = 32'h77;
        #1;
        check("conf_ack3", 32'(ack_o[1]), 32'h0);
        tick();
        idle();
        #1;
        check("conf_busy_kept", 32'(busy1_o[1]), 32'h1);
        check("conf_werr", 32'(werr_o[1]), 32'h0);
        check("conf_rd1", rd1_o[1], 32'h77);

        // Unreserved write sets sticky WERR.
        do_reset();
        we3 = 1'b1; a3 = 3'd2; wd3 = 32'h55; a2 = 3'd2;
        tick();
        we3 = 1'b0;
        #1;
        check("unres_rd2", rd2_o[1], 32'h55);
        for (int i = 0; i < 10; i++) begin
            check("unres_werr", 32'(werr_o[1]), 32'h1);
            tick();
        end
        do_reset();

        // Forwarding (or not) of a write to the register being read.
        we3 = 1'b1; a3 = 3'd4; wd3 = 32'h11111111;
        tick();
        wd3 = 32'hA5A5A5A5; a2 = 3'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_rd2_same", rd2_o[1], 32'hA5A5A5A5);
`else
        check("byp_rd2_old", rd2_o[1], 32'h11111111);
`endif
        tick();
        we3 = 1'b0;
        #1;
        check("byp_rd2_next", rd2_o[1], 32'hA5A5A5A5);

        // Randomized traffic with occasional mid-operation resets.
        for (int c = 0; c < 2000; c++) begin
            a1  = 3'($urandom_range(7));
            a2  = 3'($urandom_range(7));
            a3  = 3'($urandom_range(7));
            ra  = 3'($urandom_range(7));
            we3 = 1'($urandom_range(1));
            res = 1'($urandom_range(1));
            wd3 = $urandom;
            if ($urandom_range(63) == 0) do_reset();
            else tick();
        end

        idle();
        tick();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_nport.md
Name: regfile_nport

Overview:
- Parametrised next-generation register file for the single-cycle/multi-cycle datapath.
- Generalised in word width and register count. Two combinational read ports and one synchronous write port.
- Adds asynchronous reset, an optional hardwired zero register, a per-register pending-write scoreboard with reserve/release handshake, and a write-port error flag.
- Sits between decode (A1/A2/A3, reserve) and writeback (WD3/WE3).

Parameters:
- XLEN, 32, data word width in bits.
- NREGS, 8, number of registers; power of two, 2..32.
- AW, $clog2(NREGS), address width; derived, not overridden.
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is ordinary.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  asynchronous active-high reset.
- A1  input  AW  read port 1 address.
- A2  input  AW  read port 2 address.
- A3  input  AW  write address.
- WE3  input  1  write enable.
- WD3  input  XLEN  write data.
- RES  input  1  reserve request: mark register RA pending.
- RA  input  AW  reserve address.
- RD1  output  XLEN  read data port 1.
- RD2  output  XLEN  read data port 2.
- BUSY1  output  1  register A1 has a pending write.
- BUSY2  output  1  register A2 has a pending write.
- RES_ACK  output  1  reserve accepted this cycle.
- WERR  output  1  sticky flag: a write hit a non-pending register.

Behaviour:
- Storage: NREGS x XLEN flops plus a pending[NREGS] bit vector.
- Reset: RST high clears all registers to 0, all pending bits to 0, and WERR to 0, immediately and independent of CLK.
  - While RST is high, writes and reserves are ignored.
  - RES_ACK is 0 during reset.
- Reads: RD1/RD2 are combinational from the storage array with zero cycle latency.
  - With ZERO_REG=1 and address 0, the read returns 0.
- Writes: on posedge CLK with WE3=1, reg[A3] <= WD3.
  - Without bypass, the new value is visible on reads the cycle after the edge.
  - With ZERO_REG=1 and A3=0, the write is discarded.
- Scoreboard:
  - On posedge CLK, RES=1 and pending[RA]=0 sets pending[RA].
  - RES_ACK is combinational: RES & ~pending[RA] & ~RST.
  - RES on an already-pending register is refused (RES_ACK=0) with no state change. The requester holds RES until acked.
  - WE3=1 clears pending[A3].
  - WE3 to a register whose pending bit is 0 still writes the data and sets WERR=1. WERR stays set until reset.
  - With ZERO_REG=1, register 0 is never pending: RES to 0 is acked with no state change, and BUSY for address 0 is 0.
- Simultaneous events:
  - WE3 and RES to the same register in one cycle: the write clears, then the reserve sets, so the pending bit ends at 1. RES_ACK is computed from the pre-edge pending bit.
  - WE3 and RES to different registers: both take effect.
  - A1 equal to A2: both ports return the same value and the same BUSY.
- BUSY1 = pending[A1] and BUSY2 = pending[A2], both combinational, pre-edge state.
- Reset mid-operation: a pending write is lost and the scoreboard is cleared. Writeback after reset sets WERR.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If WE3=1 and A3 equals A1 (resp. A2), RD1 (resp. RD2) = WD3 in the same cycle. Register 0 is excluded when ZERO_REG=1.
  - BUSYx is forced to 0 when the forwarded write clears that register.
- Undefined: reads always come from storage; a read of the register being written returns the old value that cycle.

Decomposition:
- Package regfile_pkg holds:
  - default XLEN and NREGS localparams;
  - a typedef for the register word (logic [XLEN-1:0]);
  - a function decode_onehot(addr) returning an NREGS-bit one-hot write/reserve select.
- One sub-module: regfile_scoreboard, containing the pending vector, RES_ACK, BUSY1/BUSY2 and WERR logic.
- The storage array and read muxes stay in the top module.

Test Plan:
- Reset: pulse RST mid-cycle -> all RDx=0, BUSYx=0, WERR=0 immediately, before any CLK edge.
- Basic write/read (XLEN=32, NREGS=8): RES RA=3, then WE3 A3=3 WD3=0xDEADBEEF, then A1=3 -> RD1=0xDEADBEEF next cycle, BUSY1 1 -> 0, WERR=0.
- Zero register: WE3 A3=0 WD3=0x1234 -> RD1 with A1=0 reads 0; same write with ZERO_REG=0 -> reads 0x1234.
- Scoreboard conflict: RES RA=5 twice in consecutive cycles -> RES_ACK=1 then 0. In the same cycle, WE3 A3=5 plus RES RA=5 -> pending[5] stays 1, RES_ACK=0.
- Unreserved write: WE3 A3=2 with no prior RES -> reg2 updated and WERR=1, held across 10 cycles until RST.
- Bypass (REGFILE_BYPASS_EN defined): WE3 A3=4 WD3=0xA5A5A5A5 with A2=4 -> RD2=0xA5A5A5A5 in the same cycle. With the macro undefined, RD2 shows the old value until the next cycle.
